// File: rtl/nic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nic_pkg
// Description : Shared constants for the NIC: PE register map addresses and
//               bit positions inside the status words.
// Revision    : 1.0 - initial release
// ============================================================================
package nic_pkg;

    // PE register map
    localparam logic [1:0] NIC_IN_BUF   = 2'b00;
    localparam logic [1:0] NIC_IN_STAT  = 2'b01;
    localparam logic [1:0] NIC_OUT_BUF  = 2'b10;
    localparam logic [1:0] NIC_OUT_STAT = 2'b11;

    // Status word layout
    localparam int STAT_FLAG   = 0;
    localparam int STAT_CNT_LO = 8;
    localparam int STAT_CNT_HI = 15;

endpackage : nic_pkg
`default_nettype wire

// File: rtl/nic_if.sv
`default_nettype none
// ============================================================================
// Module      : nic_if
// Description : PE register bus plus router ingress/egress handshake of the
//               NIC, bundled as one interface.
//               slave  - NIC side (nic_fifo)
//               master - PE/router side (bench or wrapper)
//               Ports carried: nicEn, nicWrEn, addr, d_in, d_out,
//               net_si, net_ri, net_di, net_so, net_ro, net_do, net_polarity
// Revision    : 1.0 - initial release
// ============================================================================
interface nic_if #(
    parameter int DATA_W = 64
);
    // PE register access
    logic              nicEn;
    logic              nicWrEn;
    logic [1:0]        addr;
    logic [DATA_W-1:0] d_in;
    logic [DATA_W-1:0] d_out;

    // Router ingress
    logic              net_si;
    logic              net_ri;
    logic [DATA_W-1:0] net_di;

    // Router egress
    logic              net_so;
    logic              net_ro;
    logic [DATA_W-1:0] net_do;
    logic              net_polarity;

    modport slave (
        input  nicEn, nicWrEn, addr, d_in,
        output d_out,
        input  net_si, net_di,
        output net_ri,
        output net_so, net_do,
        input  net_ro, net_polarity
    );

    modport master (
        output nicEn, nicWrEn, addr, d_in,
        input  d_out,
        output net_si, net_di,
        input  net_ri,
        input  net_so, net_do,
        output net_ro, net_polarity
    );

endinterface : nic_if
`default_nettype wire

// File: rtl/nic_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : nic_sync_fifo
// Description : Single-clock FIFO with registered occupancy. The head entry
//               is visible on rdata whenever the FIFO is non-empty.
//               Ports: clk, rst, push, pop, wdata, rdata, full, empty, count
// Revision    : 1.0 - initial release
// ============================================================================
module nic_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic [WIDTH-1:0] wdata,
    output logic      [WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic      [CW-1:0]    count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_push;
    logic w_pop;

    // Flags come from the registered count only: a full FIFO cannot take a
    // push in the cycle it pops, and an empty one cannot forward a push.
    assign full   = (r_count == CW'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign rdata  = r_mem[r_rd_ptr];

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Power-of-two depth: pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : nic_sync_fifo
`default_nettype wire

// File: rtl/nic_fifo.sv
`default_nettype none
// ============================================================================
// Module      : nic_fifo
// Description : NIC between one PE and its router port. Router-to-PE ingress
//               FIFO and PE-to-router egress FIFO, PE register interface
//               decoded by addr, optional egress gating on the VC bit.
//               Ports: clk, reset, bus (nic_if.slave)
// Revision    : 1.0 - initial release
// ============================================================================
module nic_fifo
    import nic_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int IN_DEPTH   = 4,
    parameter int OUT_DEPTH  = 4,
    parameter bit STRICT_POL = 1'b1
) (
    input  wire logic clk,
    input  wire logic reset,
    nic_if.slave      bus
);

    localparam int IN_CW  = $clog2(IN_DEPTH) + 1;
    localparam int OUT_CW = $clog2(OUT_DEPTH) + 1;

    logic [DATA_W-1:0] w_in_head;
    logic              w_in_full;
    logic              w_in_empty;
    logic [IN_CW-1:0]  w_in_count;
    logic              w_in_push;
    logic              w_in_pop;

    logic [DATA_W-1:0] w_out_head;
    logic              w_out_full;
    logic              w_out_empty;
    logic [OUT_CW-1:0] w_out_count;
    logic              w_out_push;
    logic              w_send;

    logic              w_rd;
    logic [DATA_W-1:0] w_rd_data;

    logic [DATA_W-1:0] r_d_out;
    logic              r_net_so;
    logic [DATA_W-1:0] r_net_do;

    // Ingress ready reflects registered occupancy only.
    assign bus.net_ri = ~reset & ~w_in_full;
    assign w_in_push  = bus.net_si & bus.net_ri;

    assign w_rd       = bus.nicEn & ~bus.nicWrEn;
    assign w_in_pop   = w_rd & (bus.addr == NIC_IN_BUF) & ~w_in_empty;
    assign w_out_push = bus.nicEn & bus.nicWrEn & (bus.addr == NIC_OUT_BUF) & ~w_out_full;

    // The egress head is released only when the router has room and, in
    // strict mode, its VC bit matches the current router polarity.
    assign w_send = ~w_out_empty & bus.net_ro &
                    (!STRICT_POL || (w_out_head[DATA_W-1] == bus.net_polarity));

    nic_sync_fifo #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_ingress (
        .clk   (clk),
        .rst   (reset),
        .push  (w_in_push),
        .pop   (w_in_pop),
        .wdata (bus.net_di),
        .rdata (w_in_head),
        .full  (w_in_full),
        .empty (w_in_empty),
        .count (w_in_count)
    );

    nic_sync_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_egress (
        .clk   (clk),
        .rst   (reset),
        .push  (w_out_push),
        .pop   (w_send),
        .wdata (bus.d_in),
        .rdata (w_out_head),
        .full  (w_out_full),
        .empty (w_out_empty),
        .count (w_out_count)
    );

    // Read mux; counts are zero-extended into the 8-bit count field.
    always_comb begin
        w_rd_data = '0;
        case (bus.addr)
            NIC_IN_BUF: begin
                if (!w_in_empty) begin
                    w_rd_data = w_in_head;
                end
            end
            NIC_IN_STAT: begin
                w_rd_data[STAT_FLAG]                = ~w_in_empty;
                w_rd_data[STAT_CNT_HI:STAT_CNT_LO]  = 8'(w_in_count);
            end
            NIC_OUT_STAT: begin
                w_rd_data[STAT_FLAG]                = w_out_full;
                w_rd_data[STAT_CNT_HI:STAT_CNT_LO]  = 8'(w_out_count);
            end
            default: w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_d_out  <= '0;
            r_net_so <= 1'b0;
            r_net_do <= '0;
        end else begin
            if (w_rd) begin
                r_d_out <= w_rd_data;
            end
            r_net_so <= w_send;
            r_net_do <= w_send ? w_out_head : '0;
        end
    end

    assign bus.d_out  = r_d_out;
    assign bus.net_so = r_net_so;
    assign bus.net_do = r_net_do;

endmodule : nic_fifo
`default_nettype wire
